// File: rtl/snn_ctrl.sv
// snn_ctrl: phase sequencer that drives buffer loading, the conv/pool/fc/dist schedule and clock-gating enables
module snn_ctrl #(
  parameter int PIPE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       cg_en,
  output logic       img_we,
  output logic [6:0] img_addr,
  output logic       ker_we,
  output logic [3:0] ker_addr,
  output logic       w_we,
  output logic [1:0] w_addr,
  output logic       conv_valid,
  output logic       conv_img,
  output logic [1:0] conv_row,
  output logic [1:0] conv_col,
  output logic       pool_valid,
  output logic       pool_img,
  output logic [1:0] pool_idx,
  output logic       fc_valid,
  output logic       fc_img,
  output logic       dist_valid,
  output logic       out_valid,
  output logic       busy,
  output logic       cg_load_en,
  output logic       cg_conv_en,
  output logic       cg_pool_en,
  output logic       cg_fc_en
);
  typedef enum logic [2:0] {IDLE, LOAD, CONV, GAP, POOL, FC, DIST, OUT} state_t;
  state_t     state, state_d, ret, ret_d, nxt;
  logic [6:0] lc, lc_d;
  logic [4:0] k, k_d;
  logic [1:0] gc, gc_d;
  logic       done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ret   <= IDLE;
      lc    <= '0;
      k     <= '0;
      gc    <= '0;
    end else begin
      state <= state_d;
      ret   <= ret_d;
      lc    <= lc_d;
      k     <= k_d;
      gc    <= gc_d;
    end
  // each compute phase ends by routing through GAP (or straight to the next phase when PIPE_LAT is 0)
  always_comb begin
    state_d = state;
    ret_d   = ret;
    lc_d    = lc;
    k_d     = k;
    gc_d    = gc;
    nxt     = IDLE;
    done    = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        state_d = LOAD;
        lc_d    = 7'd1;
      end
      LOAD: if (in_valid) begin
        lc_d = lc == 7'd71 ? 7'd0 : lc + 7'd1;
        if (lc == 7'd71) begin
          state_d = CONV;
          k_d     = '0;
        end
      end
      CONV: begin
        k_d  = k + 5'd1;
        done = k == 5'd31;
        nxt  = POOL;
      end
      POOL: begin
        k_d  = k + 5'd1;
        done = k == 5'd7;
        nxt  = FC;
      end
      FC: begin
        k_d  = k + 5'd1;
        done = k == 5'd1;
        nxt  = DIST;
      end
      DIST: begin
        done = 1'b1;
        nxt  = OUT;
      end
      GAP: begin
        gc_d = gc + 2'd1;
        if (gc == 2'(PIPE_LAT - 1)) begin
          state_d = ret;
          k_d     = '0;
          gc_d    = '0;
        end
      end
      OUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (done) begin
      k_d     = '0;
      gc_d    = '0;
      ret_d   = nxt;
      state_d = PIPE_LAT == 0 ? nxt : GAP;
    end
  end
  assign img_we     = rst_n && in_valid && (state == IDLE || state == LOAD);
  assign img_addr   = lc;
  assign ker_we     = img_we && lc < 7'd9;
  assign ker_addr   = lc[3:0];
  assign w_we       = img_we && lc < 7'd4;
  assign w_addr     = lc[1:0];
  assign conv_valid = state == CONV;
  assign conv_img   = conv_valid && k[4];
  assign conv_row   = conv_valid ? k[3:2] : 2'd0;
  assign conv_col   = conv_valid ? k[1:0] : 2'd0;
  assign pool_valid = state == POOL;
  assign pool_img   = pool_valid && k[2];
  assign pool_idx   = pool_valid ? k[1:0] : 2'd0;
  assign fc_valid   = state == FC;
  assign fc_img     = fc_valid && k[0];
  assign dist_valid = state == DIST;
  assign out_valid  = state == OUT;
  assign busy       = state != IDLE;
  assign cg_load_en = !cg_en || img_we;
  assign cg_conv_en = !cg_en || conv_valid;
  assign cg_pool_en = !cg_en || pool_valid;
  assign cg_fc_en   = !cg_en || fc_valid || dist_valid;
endmodule
